axis_bus_demux_pkt: RTL and testbench

Packet-aware, parametrised AXI-Stream demultiplexer that routes one upstream stream to one of `NUM_CH` downstream FIFOs, with full tdata/tvalid/tlast/tready routing. The route is locked once per packet from `bus_sel` and held until the packet's `tlast` beat has been accepted. Packets with an invalid select are consumed and discarded, and counted. The block sits between the shared input stream and the per-channel FIFO bank, in the slot of the combinational tready-only demux.

---
 rtl/axis_bus_demux_pkt_if.sv | 25 ++
 rtl/axis_bus_demux_pkt.sv | 119 +++++++++++
 tb/tb_axis_bus_demux_pkt.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_bus_demux_pkt_if.sv
// AXI-Stream bundle for the packet demux: one upstream stream, NUM_CH downstream streams.
// The slave modport is the demux view; the master modport is the source/sink view.
interface axis_bus_demux_pkt_if #(
  parameter int unsigned NUM_CH = 12,
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]        axis_in_tdata;
  logic                     axis_in_tvalid;
  logic                     axis_in_tlast;
  logic                     axis_in_tready;
  logic [NUM_CH*DATA_W-1:0] axis_out_tdata;
  logic [NUM_CH-1:0]        axis_out_tvalid;
  logic [NUM_CH-1:0]        axis_out_tlast;
  logic [NUM_CH-1:0]        axis_out_tready;

  modport slave (
    input  axis_in_tdata, axis_in_tvalid, axis_in_tlast, axis_out_tready,
    output axis_in_tready, axis_out_tdata, axis_out_tvalid, axis_out_tlast
  );

  modport master (
    output axis_in_tdata, axis_in_tvalid, axis_in_tlast, axis_out_tready,
    input  axis_in_tready, axis_out_tdata, axis_out_tvalid, axis_out_tlast
  );
endinterface

// File: rtl/axis_bus_demux_pkt.sv
// Packet-aware AXI-Stream demux: route is locked per packet from bus_sel, beats pass through a
// single tagged output register; packets with an invalid select are swallowed and counted.
module axis_bus_demux_pkt #(
  parameter int unsigned NUM_CH = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           bus_sel,
  axis_bus_demux_pkt_if.slave  bus,
  output logic                 route_busy,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [CH_W-1:0]   ch;
  } beat_t;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  beat_t            reg_q, reg_d;
  logic             reg_v_q, reg_v_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic sel_ok_c;
  logic out_rdy_c;
  logic in_rdy_c;

  assign sel_ok_c  = bus_sel[7] && (bus_sel[6:0] < 7'(NUM_CH));
  // Drain always follows the register's own tag, never the currently locked channel.
  assign out_rdy_c = bus.axis_out_tready[reg_q.ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      reg_q      <= '0;
      reg_v_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      reg_q      <= reg_d;
      reg_v_q    <= reg_v_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    reg_d      = reg_q;
    reg_v_d    = reg_v_q;
    drop_cnt_d = drop_cnt_q;
    in_rdy_c   = 1'b0;

    if (reg_v_q && out_rdy_c) begin
      reg_v_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.axis_in_tvalid) begin
          if (sel_ok_c) begin
            ch_d    = CH_W'(bus_sel[6:0]);
            state_d = PASS;
          end else begin
            state_d = DROP;
          end
        end
      end
      PASS: begin
        in_rdy_c = !reg_v_q || out_rdy_c;
        if (bus.axis_in_tvalid && in_rdy_c) begin
          reg_d.data = bus.axis_in_tdata;
          reg_d.last = bus.axis_in_tlast;
          reg_d.ch   = ch_q;
          reg_v_d    = 1'b1;
          if (bus.axis_in_tlast) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        in_rdy_c = 1'b1;
        if (bus.axis_in_tvalid && bus.axis_in_tlast) begin
          state_d = IDLE;
          if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel valid/last decode from the tagged register.
  always_comb begin
    bus.axis_out_tvalid = '0;
    bus.axis_out_tlast  = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      bus.axis_out_tvalid[k] = reg_v_q && (reg_q.ch == CH_W'(k));
      bus.axis_out_tlast[k]  = reg_v_q && (reg_q.ch == CH_W'(k)) && reg_q.last;
    end
  end

  assign bus.axis_out_tdata = {NUM_CH{reg_q.data}};
  assign bus.axis_in_tready = in_rdy_c;
  assign route_busy         = (state_q != IDLE);
  assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_axis_bus_demux_pkt.sv
// Scoreboard bench for axis_bus_demux_pkt; a second instance with a 2-bit drop counter
// shadows the same input stream to exercise counter saturation.
module tb_axis_bus_demux_pkt;

  localparam int unsigned NUM_CH = 12;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_sel;
  logic        busy;
  logic        sat_busy;
  logic [15:0] drop_cnt;
  logic [1:0]  sat_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cyc = 0;
  exp_t sb_q[$];

  axis_bus_demux_pkt_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();
  axis_bus_demux_pkt_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus2 ();

  assign bus2.axis_in_tdata   = bus.axis_in_tdata;
  assign bus2.axis_in_tvalid  = bus.axis_in_tvalid;
  assign bus2.axis_in_tlast   = bus.axis_in_tlast;
  assign bus2.axis_out_tready = bus.axis_out_tready;

  axis_bus_demux_pkt #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus(bus),
    .route_busy(busy), .drop_cnt(drop_cnt)
  );

  axis_bus_demux_pkt #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus(bus2),
    .route_busy(sat_busy), .drop_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (busy) busy_cyc++;

  // Monitor: pops the scoreboard on every downstream transfer.
  always @(negedge clk) begin
    int ch;
    exp_t e;
    if (!rst && bus.axis_out_tvalid != '0) begin
      chk("out_onehot", 64'($countones(bus.axis_out_tvalid)), 64'd1);
      chk("out_tlast_gate", 64'(bus.axis_out_tlast & ~bus.axis_out_tvalid), 64'd0);
      if (|(bus.axis_out_tvalid & bus.axis_out_tready)) begin
        ch = 0;
        for (int k = 0; k < int'(NUM_CH); k++)
          if (bus.axis_out_tvalid[k] && bus.axis_out_tready[k]) ch = k;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got beat %0h on ch %0d expected none",
                   bus.axis_out_tdata[ch*32 +: 32], ch);
        end else begin
          e = sb_q.pop_front();
          chk("out_ch", 64'(ch), 64'(e.ch));
          chk("out_data", 64'(bus.axis_out_tdata[ch*32 +: 32]), 64'(e.data));
          chk("out_last", 64'(bus.axis_out_tlast[ch]), 64'(e.last));
        end
      end
    end
  end

  // Sends one packet starting in IDLE; optionally swaps bus_sel after beat sw_after.
  task automatic send_pkt(input logic [7:0] sel, input int n, input logic [31:0] base,
                          input int sw_after, input logic [7:0] alt, output int cyc);
    bit   ok;
    bit   acc;
    int   waits;
    exp_t e;
    ok      = sel[7] && (sel[6:0] < 7'(NUM_CH));
    bus_sel = sel;
    cyc     = 0;
    for (int i = 0; i < n; i++) begin
      bus.axis_in_tvalid = 1'b1;
      bus.axis_in_tdata  = base + 32'(i);
      bus.axis_in_tlast  = (i == n - 1);
      waits = 0;
      acc   = 1'b0;
      while (!acc) begin
        @(negedge clk);
        if (i == 0 && waits == 0) begin
          chk("idle_tready", 64'(bus.axis_in_tready), 64'd0);
          chk("idle_busy", 64'(busy), 64'd0);
        end
        acc = bus.axis_in_tready;
        @(posedge clk);
        cyc++;
        waits++;
        if (!acc && waits > 50) begin
          chk("accept_timeout", 64'(waits), 64'd0);
          bus.axis_in_tvalid = 1'b0;
          bus.axis_in_tlast  = 1'b0;
          return;
        end
      end
      if (ok) begin
        e.ch   = int'(sel[6:0]);
        e.data = base + 32'(i);
        e.last = (i == n - 1);
        sb_q.push_back(e);
      end
      #1;
      if (i == sw_after) bus_sel = alt;
    end
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int waits;
    logic [7:0] bad_sel [5];
    bad_sel[0] = 8'd5;   bad_sel[1] = 8'd255; bad_sel[2] = 8'd140;
    bad_sel[3] = 8'd0;   bad_sel[4] = 8'd204;

    rst = 1'b1;
    bus_sel = 8'd0;
    bus.axis_in_tvalid  = 1'b0;
    bus.axis_in_tlast   = 1'b0;
    bus.axis_in_tdata   = '0;
    bus.axis_out_tready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_tready", 64'(bus.axis_in_tready), 64'd0);
    chk("rst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.axis_out_tlast), 64'd0);
    chk("rst_tdata_lo", bus.axis_out_tdata[63:0], 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Basic routing to ch 3 at full rate.
    busy_cyc = 0;
    send_pkt(8'd131, 4, 32'hA0, -1, 8'd0, cyc);
    chk("basic_cycles", 64'(cyc), 64'd5);
    idle(3);
    chk("basic_busy_cycles", 64'(busy_cyc), 64'd4);

    // Select change mid-packet is ignored; next packet follows the new select.
    send_pkt(8'd128, 3, 32'hB0, 1, 8'd135, cyc);
    send_pkt(8'd135, 2, 32'hB8, -1, 8'd0, cyc);
    chk("next_pkt_cycles", 64'(cyc), 64'd3);
    idle(3);

    // Backpressure on ch 5 for 3 cycles while beat 0xC1 sits in the register.
    fork
      send_pkt(8'd133, 6, 32'hC0, -1, 8'd0, cyc);
      begin
        repeat (3) @(posedge clk);
        #1 bus.axis_out_tready[5] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_tready", 64'(bus.axis_in_tready), 64'd0);
          chk("stall_valid", 64'(bus.axis_out_tvalid[5]), 64'd1);
          chk("stall_hold", 64'(bus.axis_out_tdata[5*32 +: 32]), 64'hC1);
        end
        @(posedge clk);
        #1 bus.axis_out_tready[5] = 1'b1;
      end
    join
    chk("bp_cycles", 64'(cyc), 64'd10);
    idle(3);

    // Invalid selects are consumed at full rate and counted.
    send_pkt(8'd0, 3, 32'hD0, -1, 8'd0, cyc);
    chk("drop0_cycles", 64'(cyc), 64'd4);
    send_pkt(8'd140, 3, 32'hD8, -1, 8'd0, cyc);
    chk("drop1_cycles", 64'(cyc), 64'd4);
    idle(2);
    chk("drop_cnt_2", 64'(drop_cnt), 64'd2);
    chk("sat_cnt_2", 64'(sat_cnt), 64'd2);

    // Saturation of the 2-bit counter after a fresh reset.
    rst = 1'b1;
    idle(1);
    chk("rst2_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 5; k++) begin
      send_pkt(bad_sel[k], 1, 32'h50 + 32'(k), -1, 8'd0, cyc);
      chk("sat_drop_cnt", 64'(drop_cnt), 64'(k + 1));
      chk("sat_cnt", 64'(sat_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    idle(2);

    // Reset while a ch 2 beat is held in the register.
    bus.axis_out_tready[2] = 1'b0;
    bus_sel = 8'd130;
    bus.axis_in_tvalid = 1'b1;
    bus.axis_in_tdata  = 32'hE0;
    bus.axis_in_tlast  = 1'b0;
    waits = 0;
    while (!(busy && bus.axis_in_tready) && waits < 50) begin
      @(posedge clk);
      #1 waits++;
    end
    @(posedge clk);
    #1;
    chk("pre_rst_valid2", 64'(bus.axis_out_tvalid), 64'h004);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    chk("async_rst_tdata", bus.axis_out_tdata[63:0], 64'd0);
    chk("async_rst_in_tready", 64'(bus.axis_in_tready), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    sb_q.delete();
    bus.axis_in_tvalid = 1'b0;
    idle(1);
    rst = 1'b0;
    bus.axis_out_tready = '1;
    idle(1);
    send_pkt(8'd132, 2, 32'hF0, -1, 8'd0, cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd3);

    waits = 0;
    while (sb_q.size() != 0 && waits < 20) begin
      @(posedge clk);
      waits++;
    end
    idle(2);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
